// File: rtl/nn_pkg.sv
// Shared constants for the fully-connected layer pipeline: default word width,
// per-layer neuron counts and the serializer state encoding.
package nn_pkg;

   localparam int DATA_W_DEFAULT  = 16;
   localparam int L1_NUM_NEURONS  = 30;
   localparam int L2_NUM_NEURONS  = 5;

   // Serializer states, kept as plain constants for compatibility with older tools
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

endpackage

// File: rtl/layer_stream_serializer.sv
// Captures one parallel layer output vector and replays it one word per beat,
// tagged with the element index, into the next layer's serial input.
module layer_stream_serializer
   import nn_pkg::*;
#(
   parameter  int NUM_NEURONS = L1_NUM_NEURONS,
   parameter  int data_width  = DATA_W_DEFAULT,
   localparam int IDX_W       = $clog2(NUM_NEURONS)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_NEURONS*data_width-1:0] in_vec,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [data_width-1:0]             out_data,
   output logic [IDX_W-1:0]                  out_index,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              out_last,
   output logic                              busy,
   output logic                              drop_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   logic [0:0]            state;
   logic [IDX_W-1:0]      idx;
   logic [data_width-1:0] buffer [NUM_NEURONS];
   logic                  in_valid_q;
   logic                  streaming;
   logic                  at_last;

   assign streaming = (state == ST_STREAM);
   assign at_last   = (idx == LAST_IDX);

   // Frame sequencing: capture in IDLE, advance the element index on each accepted beat
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else if (!streaming) begin
         if (in_valid) begin
            state <= ST_STREAM;
            idx   <= '0;
         end
      end else if (out_ready) begin
         if (at_last) begin
            state <= ST_IDLE;
            idx   <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   // Single frame buffer, written only on the capture edge so later in_vec changes are ignored
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_NEURONS; i++) buffer[i] <= '0;
      end else if (!streaming && in_valid) begin
         for (int i = 0; i < NUM_NEURONS; i++)
            buffer[i] <= in_vec[i*data_width +: data_width];
      end
   end

   // Lost-frame flag: a source that keeps valid high while waiting on in_ready is only
   // backpressured; a valid that newly rises during a stream is a frame with nowhere to go.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_valid_q <= 1'b0;
         drop_err   <= 1'b0;
      end else begin
         in_valid_q <= in_valid;
         if (streaming && in_valid && !in_valid_q) drop_err <= 1'b1;
      end
   end

   assign in_ready  = !streaming;
   assign busy      = streaming;
   assign out_valid = streaming;
   assign out_index = idx;
   assign out_last  = streaming && at_last;
   assign out_data  = streaming ? buffer[idx] : '0;

endmodule

// File: tb/tb_layer_stream_serializer.sv
// Directed bench for layer_stream_serializer: a 30x16 instance for the main scenarios and
// a 5x8 instance for the small, non-power-of-two configuration.
module tb_layer_stream_serializer;

   localparam int N   = 30;
   localparam int DW  = 16;
   localparam int N5  = 5;
   localparam int DW5 = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst = 1'b0;
   logic [N*DW-1:0]   in_vec = '0;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic              in_ready;
   logic [DW-1:0]     out_data;
   logic [4:0]        out_index;
   logic              out_valid, out_last, busy, drop_err;

   logic [N5*DW5-1:0] in_vec5 = '0;
   logic              in_valid5 = 1'b0;
   logic              out_ready5 = 1'b0;
   logic              in_ready5;
   logic [DW5-1:0]    out_data5;
   logic [2:0]        out_index5;
   logic              out_valid5, out_last5, busy5, drop_err5;

   int checks = 0;
   int fails  = 0;

   layer_stream_serializer #(.NUM_NEURONS(N), .data_width(DW)) dut (
      .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy), .drop_err(drop_err));

   layer_stream_serializer #(.NUM_NEURONS(N5), .data_width(DW5)) dut5 (
      .clk(clk), .rst(rst), .in_vec(in_vec5), .in_valid(in_valid5), .in_ready(in_ready5),
      .out_data(out_data5), .out_index(out_index5), .out_valid(out_valid5),
      .out_ready(out_ready5), .out_last(out_last5), .busy(busy5), .drop_err(drop_err5));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N*DW-1:0] ramp(input logic [15:0] step, input logic [15:0] base);
      logic [N*DW-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = base + 16'(i) * step;
      return v;
   endfunction

   task automatic test_reset;
      rst = 1'b0;
      tick();
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      checks++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %0b want 0", out_last); end
      checks++; if (out_index !== 5'd0) begin fails++; $display("FAIL reset_out_index: got %0d want 0", out_index); end
      checks++; if (out_data !== 16'h0000) begin fails++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
      checks++; if (drop_err !== 1'b0) begin fails++; $display("FAIL reset_drop_err: got %0b want 0", drop_err); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_basic_stream;
      logic [15:0] exp;
      in_vec = ramp(16'h0101, 16'h0000);
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         exp = 16'(i) * 16'h0101;
         checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid[%0d]: got %0b want 1", i, out_valid); end
         checks++; if (out_index !== 5'(i)) begin fails++; $display("FAIL basic_index[%0d]: got %0d want %0d", i, out_index, i); end
         checks++; if (out_data !== exp) begin fails++; $display("FAIL basic_data[%0d]: got %h want %h", i, out_data, exp); end
         checks++; if (out_last !== (i == N-1)) begin fails++; $display("FAIL basic_last[%0d]: got %0b want %0b", i, out_last, (i == N-1)); end
         checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_in_ready[%0d]: got %0b want 0", i, in_ready); end
         tick();
      end
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_end_in_ready: got %0b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_end_valid: got %0b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_end_busy: got %0b want 0", busy); end
   endtask

   task automatic test_stall;
      int  exp_idx;
      bit  done;
      bit  xfer;
      in_vec = ramp(16'h0101, 16'h0000);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      exp_idx = 0;
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         out_ready = ((c % 4) == 0) || ((c % 4) == 3);
         checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[c%0d]: got %0b want 1", c, out_valid); end
         checks++; if (out_index !== 5'(exp_idx)) begin fails++; $display("FAIL stall_index[c%0d]: got %0d want %0d", c, out_index, exp_idx); end
         checks++; if (out_data !== 16'(exp_idx) * 16'h0101) begin fails++; $display("FAIL stall_data[c%0d]: got %h want %h", c, out_data, 16'(exp_idx) * 16'h0101); end
         checks++; if (out_last !== (exp_idx == N-1)) begin fails++; $display("FAIL stall_last[c%0d]: got %0b want %0b", c, out_last, (exp_idx == N-1)); end
         xfer = out_ready;
         tick();
         if (xfer) begin
            if (exp_idx == N-1) done = 1'b1;
            else exp_idx++;
         end
      end
      checks++; if (!done) begin fails++; $display("FAIL stall_timeout: got index %0d want %0d", exp_idx, N-1); end
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_end_in_ready: got %0b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_end_valid: got %0b want 0", out_valid); end
      out_ready = 1'b1;
   endtask

   task automatic test_overflow;
      logic [15:0] exp;
      out_ready = 1'b1;
      in_vec = ramp(16'h0101, 16'h0000);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i == 5) begin
            in_vec = ramp(16'h0001, 16'h8000);
            in_valid = 1'b1;
         end
         exp = 16'(i) * 16'h0101;
         checks++; if (out_index !== 5'(i)) begin fails++; $display("FAIL ovf_index[%0d]: got %0d want %0d", i, out_index, i); end
         checks++; if (out_data !== exp) begin fails++; $display("FAIL ovf_data[%0d]: got %h want %h", i, out_data, exp); end
         if (i >= 6) begin
            checks++; if (drop_err !== 1'b1) begin fails++; $display("FAIL ovf_drop_err[%0d]: got %0b want 1", i, drop_err); end
         end else begin
            checks++; if (drop_err !== 1'b0) begin fails++; $display("FAIL ovf_drop_err_early[%0d]: got %0b want 0", i, drop_err); end
         end
         tick();
         in_valid = 1'b0;
      end
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ovf_end_in_ready: got %0b want 1", in_ready); end
      checks++; if (drop_err !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %0b want 1", drop_err); end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         exp = 16'h8000 + 16'(i);
         checks++; if (out_index !== 5'(i)) begin fails++; $display("FAIL ovf2_index[%0d]: got %0d want %0d", i, out_index, i); end
         checks++; if (out_data !== exp) begin fails++; $display("FAIL ovf2_data[%0d]: got %h want %h", i, out_data, exp); end
         tick();
      end
      checks++; if (drop_err !== 1'b1) begin fails++; $display("FAIL ovf2_sticky: got %0b want 1", drop_err); end
      rst = 1'b0;
      #1;
      checks++; if (drop_err !== 1'b0) begin fails++; $display("FAIL ovf_reset_clear: got %0b want 0", drop_err); end
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back;
      logic [15:0] exp;
      out_ready = 1'b1;
      in_vec = ramp(16'h0101, 16'h0000);
      in_valid = 1'b1;
      tick();
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < N; i++) begin
            exp = 16'(i) * 16'h0101;
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid[f%0d,%0d]: got %0b want 1", f, i, out_valid); end
            checks++; if (out_index !== 5'(i)) begin fails++; $display("FAIL b2b_index[f%0d,%0d]: got %0d want %0d", f, i, out_index, i); end
            checks++; if (out_data !== exp) begin fails++; $display("FAIL b2b_data[f%0d,%0d]: got %h want %h", f, i, out_data, exp); end
            checks++; if (drop_err !== 1'b0) begin fails++; $display("FAIL b2b_drop_err[f%0d,%0d]: got %0b want 0", f, i, drop_err); end
            tick();
         end
         checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_gap_in_ready[f%0d]: got %0b want 1", f, in_ready); end
         checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_gap_valid[f%0d]: got %0b want 0", f, out_valid); end
         if (f == 1) in_valid = 1'b0;
         tick();
      end
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end_valid: got %0b want 0", out_valid); end
      checks++; if (drop_err !== 1'b0) begin fails++; $display("FAIL b2b_end_drop_err: got %0b want 0", drop_err); end
   endtask

   task automatic test_reset_midstream;
      out_ready = 1'b1;
      in_vec = ramp(16'h0101, 16'h0000);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      checks++; if (out_index !== 5'd12) begin fails++; $display("FAIL rstmid_pre_index: got %0d want 12", out_index); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %0b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
      checks++; if (out_index !== 5'd0) begin fails++; $display("FAIL rstmid_index: got %0d want 0", out_index); end
      checks++; if (out_data !== 16'h0000) begin fails++; $display("FAIL rstmid_data: got %h want 0000", out_data); end
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_in_ready: got %0b want 1", in_ready); end
      tick();
      rst = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_release_in_ready: got %0b want 1", in_ready); end
      in_vec = ramp(16'h0001, 16'h4000);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_index !== 5'd0) begin fails++; $display("FAIL rstmid_new_index: got %0d want 0", out_index); end
      checks++; if (out_data !== 16'h4000) begin fails++; $display("FAIL rstmid_new_data: got %h want 4000", out_data); end
      for (int i = 0; i < N; i++) tick();
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_drain_in_ready: got %0b want 1", in_ready); end
   endtask

   task automatic test_small_config;
      logic [7:0] exp;
      checks++; if (dut5.IDX_W != 3) begin fails++; $display("FAIL small_idx_w: got %0d want 3", dut5.IDX_W); end
      in_vec5 = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
      out_ready5 = 1'b1;
      in_valid5 = 1'b1;
      tick();
      in_valid5 = 1'b0;
      for (int i = 0; i < N5; i++) begin
         exp = 8'hA0 + 8'(i);
         checks++; if (out_valid5 !== 1'b1) begin fails++; $display("FAIL small_valid[%0d]: got %0b want 1", i, out_valid5); end
         checks++; if (out_index5 !== 3'(i)) begin fails++; $display("FAIL small_index[%0d]: got %0d want %0d", i, out_index5, i); end
         checks++; if (out_data5 !== exp) begin fails++; $display("FAIL small_data[%0d]: got %h want %h", i, out_data5, exp); end
         checks++; if (out_last5 !== (i == N5-1)) begin fails++; $display("FAIL small_last[%0d]: got %0b want %0b", i, out_last5, (i == N5-1)); end
         tick();
      end
      checks++; if (in_ready5 !== 1'b1) begin fails++; $display("FAIL small_end_in_ready: got %0b want 1", in_ready5); end
      checks++; if (busy5 !== 1'b0) begin fails++; $display("FAIL small_end_busy: got %0b want 0", busy5); end
      checks++; if (out_index5 !== 3'd0) begin fails++; $display("FAIL small_end_index: got %0d want 0", out_index5); end
      checks++; if (drop_err5 !== 1'b0) begin fails++; $display("FAIL small_drop_err: got %0b want 0", drop_err5); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic_stream();
      test_stall();
      test_overflow();
      test_back_to_back();
      test_reset_midstream();
      test_small_config();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
